// File: rtl/key_scan_ctrl.sv
// key_scan_ctrl: walks the 32:1 key mux, debounces every key on its own
// counter and hands press/release events to the tone logic over valid/ready.

// One debounce lane. The lane only sees the mux sample while the scanner
// is sitting on this key.
module key_scan_lane #(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic smp,
  input  logic din,
  output logic kstate,
  output logic fire
);
  logic [3:0] cnt;

  // The debounced level flips on the DEBOUNCE_SCANS-th consecutive differing sample.
  always_comb fire = smp && (din != kstate) && (cnt == 4'(DEBOUNCE_SCANS - 1));

  // Any sample that agrees with the debounced level restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      kstate <= 1'b0;
    end else if (smp) begin
      if (din == kstate) begin
        cnt <= '0;
      end else if (fire) begin
        cnt    <= '0;
        kstate <= ~kstate;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end
endmodule

module key_scan_ctrl #(
  parameter int SETTLE_CYCLES  = 2,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [4:0]  sel,
  input  logic        mux_out,
  output logic [31:0] key_state,
  output logic        event_valid,
  input  logic        event_ready,
  output logic [4:0]  event_key,
  output logic        event_press,
  output logic        scan_done
);
  localparam int NUM_LANES = 32;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, EMIT} state_t;

  typedef struct packed {
    logic [4:0] key;
    logic       press;
  } evt_t;

  state_t               state, nxt;
  logic [3:0]           settle_cnt;
  logic [NUM_LANES-1:0] fire;
  logic                 any_fire;
  logic                 adv;
  logic                 load_evt;
  evt_t                 evt_q;

  // Only the lane matching sel is strobed, so at most one lane can fire.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    key_scan_lane #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .smp    ((state == SAMPLE) && (sel == 5'(k))),
      .din    (mux_out),
      .kstate (key_state[k]),
      .fire   (fire[k])
    );
  end

  assign any_fire    = |fire;
  assign event_key   = evt_q.key;
  assign event_press = evt_q.press;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // Next state; adv steps sel, load_evt captures a debounced edge.
  always_comb begin
    nxt      = state;
    adv      = 1'b0;
    load_evt = 1'b0;
    case (state)
      IDLE:   if (enable) nxt = SETTLE;
      SETTLE: if (settle_cnt == 4'(SETTLE_CYCLES - 1)) nxt = SAMPLE;
      SAMPLE: begin
        if (any_fire) begin
          load_evt = 1'b1;
          nxt      = EMIT;
        end else begin
          adv = 1'b1;
          nxt = enable ? SETTLE : IDLE;
        end
      end
      EMIT: begin
        if (event_ready) begin
          adv = 1'b1;
          nxt = enable ? SETTLE : IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // Settle counter runs only while staying in SETTLE, so every entry starts at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                settle_cnt <= '0;
    else if (state == SETTLE && nxt == SETTLE) settle_cnt <= settle_cnt + 4'd1;
    else                                      settle_cnt <= '0;
  end

  // Select stepping and the wrap pulse, registered together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel       <= '0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= adv && (sel == 5'd31);
      if (adv) sel <= sel + 5'd1;
    end
  end

  // Event holding register; fields stay frozen until the consumer takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      event_valid <= 1'b0;
      evt_q       <= '0;
    end else if (load_evt) begin
      event_valid <= 1'b1;
      evt_q       <= '{key: sel, press: mux_out};
    end else if (state == EMIT && event_ready) begin
      event_valid <= 1'b0;
    end
  end
endmodule
